// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit RAM master: access size
// encodings, FSM state encoding, width constants and the alignment rule.
package lsu_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = DATA_W / 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_WORD_ALT = 2'b11;  // decoded as a word access

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Half needs an even address, word (either word encoding) needs offset 0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    if (size == SZ_HALF && offset[0])
      bad = 1'b1;
    else if (size[1] && offset != 2'b00)
      bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the LSU RAM master.
// Load side: moves the addressed byte/half/word down to bit 0 and extends it.
// Store side: merges right-aligned store data into the addressed lanes of a
// previously read word. Lanes that would fall past byte 3 are dropped.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] rd_word,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] merged_word
);

  function automatic logic [DATA_W-1:0] extend8(input logic [7:0] b, input logic zext);
    logic signed [7:0]        s;
    logic signed [DATA_W-1:0] w;
    s = b;
    w = DATA_W'(s);
    return zext ? {{(DATA_W-8){1'b0}}, b} : w;
  endfunction

  function automatic logic [DATA_W-1:0] extend16(input logic [15:0] h, input logic zext);
    logic signed [15:0]       s;
    logic signed [DATA_W-1:0] w;
    s = h;
    w = DATA_W'(s);
    return zext ? {{(DATA_W-16){1'b0}}, h} : w;
  endfunction

  logic [4:0]        shamt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] mask_sh;

  // Extract/extend the load value and build the read-modify-write word
  always_comb begin
    shamt       = {offset, 3'b000};
    shifted     = rd_word >> shamt;
    ld_data     = shifted;
    lane_mask   = '1;
    case (size)
      SZ_BYTE: begin
        ld_data   = extend8(shifted[7:0], is_unsigned);
        lane_mask = 32'h0000_00FF;
      end
      SZ_HALF: begin
        ld_data   = extend16(shifted[15:0], is_unsigned);
        lane_mask = 32'h0000_FFFF;
      end
      default: begin
        ld_data   = shifted;
        lane_mask = '1;
      end
    endcase
    mask_sh     = lane_mask << shamt;
    merged_word = (rd_word & ~mask_sh) | ((st_data << shamt) & mask_sh);
  end

endmodule

// File: rtl/lsu_ram_master.sv
// LSU RAM master: turns one pipeline load/store request at a time into
// single-word accesses on a negedge-acting RAM. Sub-word stores are done as
// read-modify-write (RD then WR). Responses are a single-cycle pulse.
// Optional build macro LSU_MISALIGN_CHECK_EN: misaligned half/word requests
// skip the RAM and respond immediately with resp_err=1.
module lsu_ram_master
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  ram_valid,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  lsu_state_e            state_q;
  logic                  accept;
  logic                  misalign_hit;

  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     wbuf_q;

  logic [DATA_W-1:0]     ld_data;
  logic [DATA_W-1:0]     merged_word;

  assign accept = req_valid && req_ready;

  lsu_lane_align u_align (
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rd_word     (ram_rdata),
    .st_data     (wdata_q),
    .ld_data     (ld_data),
    .merged_word (merged_word)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  logic err_q;

  assign misalign_hit = is_misaligned(req_size, req_addr[1:0]);

  // Error flag is decided at acceptance and held through the response
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (accept)
      err_q <= misalign_hit;
  end

  assign resp_err = err_q;
`else
  assign misalign_hit = 1'b0;
  assign resp_err     = 1'b0;
`endif

  // Access sequencer and registered load response
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      resp_rdata <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (misalign_hit) begin
              state_q    <= ST_RESP;
              resp_rdata <= '0;
            end else if (req_wen && req_size[1]) begin
              state_q <= ST_WR;
            end else begin
              state_q <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (wen_q) begin
            state_q <= ST_WR;
          end else begin
            state_q    <= ST_RESP;
            resp_rdata <= ld_data;
          end
        end
        ST_WR: begin
          state_q    <= ST_RESP;
          resp_rdata <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request fields on acceptance; merged store word at the end of the read
  always_ff @(posedge clock) begin
    if (accept) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
    end
    if (state_q == ST_RD)
      wbuf_q <= merged_word;
  end

  // State decode; RAM address/data are forced to zero outside an access
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    ram_valid  = (state_q == ST_RD) || (state_q == ST_WR);
    ram_wen    = (state_q == ST_WR);
    ram_addr   = '0;
    ram_wdata  = '0;
    if (ram_valid)
      ram_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    if (state_q == ST_WR)
      ram_wdata = size_q[1] ? wdata_q : wbuf_q;
  end

endmodule

// File: tb/tb_lsu_ram_master.sv
// Directed bench for lsu_ram_master with a negedge-acting word RAM model.
module tb_lsu_ram_master;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_valid;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] mem [0:15];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          idle_bad = 0;
  logic [31:0] last_wdata = '0;

  lsu_ram_master #(.ADDR_WIDTH(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_valid    (ram_valid),
    .ram_wen      (ram_wen),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #5 clock = ~clock;

  // RAM model: acts on the negedge of a ram_valid cycle
  always @(negedge clock) begin
    if (ram_valid === 1'b1) begin
      if (ram_wen) begin
        mem[ram_addr[5:2]] = ram_wdata;
        last_wdata = ram_wdata;
        wr_cnt++;
      end else begin
        ram_rdata = mem[ram_addr[5:2]];
        rd_cnt++;
      end
    end else if (ram_addr !== 32'd0 || ram_wdata !== 32'd0 || ram_wen !== 1'b0) begin
      idle_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err);
    int   k;
    logic seen;
    @(posedge clock); #1;
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(posedge clock); #1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0;
    seen = 1'b0; k = 0; lat = 0; rdata = '0; err = 1'b0;
    while (!seen && k < 10) begin
      @(negedge clock);
      k++;
      if (resp_valid) begin
        seen = 1'b1; lat = k; rdata = resp_rdata; err = resp_err;
      end
    end
    chk("resp_seen", {31'd0, seen}, 32'd1);
    @(negedge clock);
    chk("resp_pulse", {31'd0, resp_valid}, 32'd0);
    chk("rdata_hold", resp_rdata, rdata);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        err;
    int          r0, w0;
    logic [31:0] old;
    logic        got_resp;

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h8899_AABB;
    mem[1] = 32'h0123_4567;

    // Reset values while reset_n is held low
    repeat (2) @(negedge clock);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_ram_valid", {31'd0, ram_valid}, 32'd0);
    chk("rst_ram_wen", {31'd0, ram_wen}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    reset_n = 1'b1;

    // Loads from 0x8899AABB
    w0 = wr_cnt;
    do_req(1'b0, 32'h8000_0001, 2'b00, 1'b0, 32'h0, lat, rd, err);
    chk("lb_s_data", rd, 32'hFFFF_FFAA);
    chk("lb_s_lat", lat, 32'd2);
    chk("lb_s_err", {31'd0, err}, 32'd0);
    do_req(1'b0, 32'h8000_0002, 2'b01, 1'b1, 32'h0, lat, rd, err);
    chk("lhu_data", rd, 32'h0000_8899);
    chk("lhu_lat", lat, 32'd2);
    do_req(1'b0, 32'h8000_0002, 2'b01, 1'b0, 32'h0, lat, rd, err);
    chk("lh_s_data", rd, 32'hFFFF_8899);
    do_req(1'b0, 32'h8000_0003, 2'b00, 1'b1, 32'h0, lat, rd, err);
    chk("lbu_data", rd, 32'h0000_0088);
    do_req(1'b0, 32'h8000_0000, 2'b00, 1'b0, 32'h0, lat, rd, err);
    chk("lb_s_lane0", rd, 32'hFFFF_FFBB);
    do_req(1'b0, 32'h8000_0000, 2'b11, 1'b0, 32'h0, lat, rd, err);
    chk("lw_sz3_data", rd, 32'h8899_AABB);
    chk("load_no_write", wr_cnt - w0, 32'd0);

    // Sub-word store: read then write, upper bits of wdata ignored
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 32'h8000_0002, 2'b00, 1'b0, 32'hCAFE_0011, lat, rd, err);
    chk("sb_lat", lat, 32'd3);
    chk("sb_reads", rd_cnt - r0, 32'd1);
    chk("sb_writes", wr_cnt - w0, 32'd1);
    chk("sb_wdata", last_wdata, 32'h8811_AABB);
    chk("sb_mem", mem[0], 32'h8811_AABB);
    chk("sb_rdata", rd, 32'd0);

    // Word store: single write, no read
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 32'h8000_0004, 2'b10, 1'b0, 32'hDEAD_BEEF, lat, rd, err);
    chk("sw_lat", lat, 32'd2);
    chk("sw_reads", rd_cnt - r0, 32'd0);
    chk("sw_writes", wr_cnt - w0, 32'd1);
    chk("sw_mem", mem[1], 32'hDEAD_BEEF);

    // Half store into the upper lane, then read back
    do_req(1'b1, 32'h8000_0006, 2'b01, 1'b0, 32'hFFFF_1234, lat, rd, err);
    chk("sh_lat", lat, 32'd3);
    chk("sh_mem", mem[1], 32'h1234_BEEF);
    do_req(1'b0, 32'h8000_0004, 2'b10, 1'b0, 32'h0, lat, rd, err);
    chk("lw_back", rd, 32'h1234_BEEF);
    do_req(1'b0, 32'h8000_0007, 2'b00, 1'b0, 32'h0, lat, rd, err);
    chk("lb_pos", rd, 32'h0000_0012);

    // Misaligned accesses
    r0 = rd_cnt; w0 = wr_cnt;
`ifdef LSU_MISALIGN_CHECK_EN
    do_req(1'b0, 32'h8000_0002, 2'b10, 1'b0, 32'h0, lat, rd, err);
    chk("mis_err", {31'd0, err}, 32'd1);
    chk("mis_rdata", rd, 32'd0);
    chk("mis_lat", lat, 32'd1);
    chk("mis_no_ram", (rd_cnt - r0) + (wr_cnt - w0), 32'd0);
    do_req(1'b0, 32'h8000_0000, 2'b10, 1'b0, 32'h0, lat, rd, err);
    chk("aligned_err_clr", {31'd0, err}, 32'd0);
    chk("aligned_data", rd, 32'h8811_AABB);
`else
    do_req(1'b0, 32'h8000_0003, 2'b01, 1'b1, 32'h0, lat, rd, err);
    chk("mis_h_data", rd, 32'h0000_0088);
    chk("mis_h_err", {31'd0, err}, 32'd0);
    do_req(1'b0, 32'h8000_0002, 2'b10, 1'b0, 32'h0, lat, rd, err);
    chk("mis_w_data", rd, 32'h0000_8811);
    chk("mis_reads", rd_cnt - r0, 32'd2);
`endif

    // Reset during the write phase of a byte store
    w0 = wr_cnt; old = mem[0];
    @(posedge clock); #1;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0000;
    req_size = 2'b00; req_wdata = 32'h0000_0055;
    @(posedge clock); #1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    @(posedge clock); #1;
    chk("rmw_in_wr", {31'd0, ram_valid & ram_wen}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'd0, ram_valid}, 32'd0);
    chk("rst_async_wen", {31'd0, ram_wen}, 32'd0);
    got_resp = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (resp_valid) got_resp = 1'b1;
    end
    chk("rst_no_write", wr_cnt - w0, 32'd0);
    chk("rst_mem_kept", mem[0], old);
    chk("rst_no_resp", {31'd0, got_resp}, 32'd0);
    reset_n = 1'b1;
    do_req(1'b0, 32'h8000_0000, 2'b10, 1'b0, 32'h0, lat, rd, err);
    chk("post_rst_load", rd, 32'h8811_AABB);

    chk("idle_bus_zero", idle_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_ram_master.md
LSU_RAM_MASTER -- requirements
Module: lsu_ram_master

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, byte address width; data width fixed at 32.
REQ-002 clock  input  1  single clock; all state on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  access request from pipeline.
REQ-005 req_ready  output  1  high only in IDLE; request accepted on posedge when req_valid&&req_ready.
REQ-006 req_wen  input  1  1=store, 0=load.
REQ-007 req_addr  input  ADDR_WIDTH  byte address.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle pulse; completion; no backpressure.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores.
REQ-013 resp_err  output  1  misaligned-request flag, qualified by resp_valid.
REQ-014 ram_valid  output  1  RAM access strobe; RAM acts on negedge of the same cycle.
REQ-015 ram_wen  output  1  RAM write enable.
REQ-016 ram_addr  output  ADDR_WIDTH  word-aligned address {req_addr[ADDR_WIDTH-1:2],2'b00}.
REQ-017 ram_wdata  output  32  full-word write data.
REQ-018 ram_rdata  input  32  RAM read word, valid at posedge ending a ram_valid cycle.

Function
REQ-019 FSM states IDLE, RD, WR, RESP; request fields latched on acceptance.
REQ-020 Transitions from IDLE on acceptance: load -> RD; word store -> WR; byte/half store -> RD.
REQ-021 RD: ram_valid=1, ram_wen=0; ram_rdata captured at end of cycle; load -> RESP, sub-word store -> WR.
REQ-022 WR: ram_valid=1, ram_wen=1; ram_wdata = captured word with addressed lanes replaced by req_wdata low bytes (read-modify-write); word store writes req_wdata directly; next -> RESP.
REQ-023 RESP: resp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in RD, WR, RESP.
REQ-024 Latency from acceptance edge to resp_valid: load 2 cycles, word store 2, sub-word store 3; back-to-back requests accepted every 3 (or 4) cycles.
REQ-025 Load extraction: byte lane addr[1:0], half lane addr[1]; extended per req_size/req_unsigned.
REQ-026 ram_valid, ram_wen decoded from state; ram_addr, ram_wdata driven 0 when ram_valid=0 (no X into the DPI RAM model).
REQ-027 resp_rdata registered; holds last value outside RESP.

Reset
REQ-028 reset_n low: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_valid=0, ram_wen=0, ram_addr=0, ram_wdata=0.
REQ-029 Reset mid-operation abandons access immediately; a partially done RMW does not write; no response issued.

Configuration
REQ-030 LSU_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 goes IDLE -> RESP with resp_err=1, resp_rdata=0, no RAM access.
REQ-031 LSU_MISALIGN_CHECK_EN undefined: resp_err tied 0; access proceeds within the addressed word, lanes beyond byte 3 dropped.

Structure
REQ-032 Shared package lsu_pkg holds size encodings, FSM state enum, width constants.
REQ-033 One sub-module lsu_lane_align: combinational load extract/extend and store merge.

Verification
REQ-034 RAM word 0x80000000=0x8899AABB; load byte signed @0x80000001 -> resp_rdata 0xFFFFFFAA, 2 cycles after acceptance.
REQ-035 Same word; load half unsigned @0x80000002 -> 0x00008899; ram_wen never 1.
REQ-036 Store byte 0x11 @0x80000002 -> one read then one write, ram_wdata 0x8811AABB, resp_valid 3 cycles after acceptance.
REQ-037 Store word 0xDEADBEEF @0x80000004 -> single write cycle, no read cycle, resp_valid after 2 cycles.
REQ-038 reset_n low during WR of a byte store -> ram_valid falls asynchronously, RAM word unchanged, no resp_valid.
REQ-039 With LSU_MISALIGN_CHECK_EN, load word @0x80000002 -> resp_err=1, ram_valid never asserted.
